intersection_scheduler: RTL

//  Demand-actuated sequencer for the two-way intersection. Vehicle detectors, a pedestrian

---
 rtl/intersection_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/intersection_scheduler.sv
// Demand-actuated two-way intersection sequencer.
// Phase order is G1 -> Y1 -> AR -> G2 -> Y2 -> AR. An exclusive WALK phase is taken
// out of AR when a pedestrian request is pending. Emergency preempt forces the
// current green through yellow and then holds all-red.
// Lamp outputs are a pure decode of the phase register.
module intersection_scheduler #(
    parameter int TICK_DIV  = 16_000_000,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int GAP_EXT   = 3,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       det1,
    input  logic       det2,
    input  logic       ped_req,
    input  logic       preempt,
    output logic       red1,
    output logic       yellow1,
    output logic       green1,
    output logic       red2,
    output logic       yellow2,
    output logic       green2,
    output logic       walk,
    output logic       dont_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [2:0] PH_G1 = 3'd0;
    localparam logic [2:0] PH_Y1 = 3'd1;
    localparam logic [2:0] PH_AR = 3'd2;
    localparam logic [2:0] PH_G2 = 3'd3;
    localparam logic [2:0] PH_Y2 = 3'd4;
    localparam logic [2:0] PH_WK = 3'd6;

    // Second counters must hold the largest duration plus one saturation code.
    localparam int TM0  = (MAX_GREEN > MIN_GREEN) ? MAX_GREEN : MIN_GREEN;
    localparam int TM1  = (TM0 > GAP_EXT)  ? TM0 : GAP_EXT;
    localparam int TM2  = (TM1 > YELLOW_T) ? TM1 : YELLOW_T;
    localparam int TM3  = (TM2 > ALLRED_T) ? TM2 : ALLRED_T;
    localparam int TMAX = (TM3 > WALK_T)   ? TM3 : WALK_T;
    localparam int SW   = $clog2(TMAX + 2);
    localparam int PW   = $clog2(TICK_DIV + 1);

    localparam logic [SW-1:0] MING = SW'(MIN_GREEN);
    localparam logic [SW-1:0] MAXG = SW'(MAX_GREEN);
    localparam logic [SW-1:0] GAPE = SW'(GAP_EXT);
    localparam logic [SW-1:0] YELT = SW'(YELLOW_T);
    localparam logic [SW-1:0] ART  = SW'(ALLRED_T);
    localparam logic [SW-1:0] WKT  = SW'(WALK_T);
    localparam logic [PW-1:0] PLST = PW'(TICK_DIV - 1);

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (&v) ? v : v + SW'(1);
    endfunction

    // sync_q[0] first stage, sync_q[1] second stage; bits {preempt, ped_req, det2, det1}
    logic [1:0][3:0] sync_q;
    logic            det1_s, det2_s, ped_s, pre_s, ped_q, ped_rise;

    logic [PW-1:0] presc;
    logic [SW-1:0] sec, sec_inc, gap1, gap2, gap1_nx, gap2_nx;
    logic          tick, call1, call2, dir;
    logic          g1_time, g2_time;
    logic [2:0]    phase_nx;
    logic          dir_nx;

    assign det1_s   = sync_q[1][0];
    assign det2_s   = sync_q[1][1];
    assign ped_s    = sync_q[1][2];
    assign pre_s    = sync_q[1][3];
    assign ped_rise = ped_s & ~ped_q;

    assign tick    = (presc == PLST);
    assign sec_inc = sat_inc(sec);

    // A state ends on the tick that completes its last second, so it lasts N*TICK_DIV clk.
    assign g1_time = (sec_inc >= MAXG) || ((sec_inc >= MING) && (gap1_nx >= GAPE));
    assign g2_time = (sec_inc >= MAXG) || ((sec_inc >= MING) && (gap2_nx >= GAPE));

    // Two-flop synchronisers for all asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {preempt, ped_req, det2, det1};
            sync_q[1] <= sync_q[0];
        end
    end

    // Detector gap timers: cleared by detection, counting seconds of silence otherwise
    always_comb begin
        gap1_nx = gap1;
        gap2_nx = gap2;
        if (det1_s)    gap1_nx = '0;
        else if (tick) gap1_nx = sat_inc(gap1);
        if (det2_s)    gap2_nx = '0;
        else if (tick) gap2_nx = sat_inc(gap2);
    end

    // Gap timer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap1 <= '0;
            gap2 <= '0;
        end else begin
            gap1 <= gap1_nx;
            gap2 <= gap2_nx;
        end
    end

    // Prescaler and second counter; restart on phase entry, frozen in AR under preempt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            sec   <= '0;
        end else if ((phase_nx != phase) || ((phase == PH_AR) && pre_s)) begin
            presc <= '0;
            sec   <= '0;
        end else if (tick) begin
            presc <= '0;
            sec   <= sec_inc;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Vehicle calls and pedestrian request latch; entry into the serving phase clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            call1       <= 1'b0;
            call2       <= 1'b0;
            ped_pending <= 1'b0;
            ped_q       <= 1'b0;
        end else begin
            ped_q <= ped_s;
            if ((phase_nx == PH_G1) && (phase != PH_G1)) call1 <= 1'b0;
            else if (det1_s && (phase != PH_G1))         call1 <= 1'b1;
            if ((phase_nx == PH_G2) && (phase != PH_G2)) call2 <= 1'b0;
            else if (det2_s && (phase != PH_G2))         call2 <= 1'b1;
            if ((phase_nx == PH_WK) && (phase != PH_WK)) ped_pending <= 1'b0;
            else if (ped_rise && (phase != PH_WK))       ped_pending <= 1'b1;
        end
    end

    // Phase state register; dir selects which green follows all-red
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_AR;
            dir   <= 1'b1;
        end else begin
            phase <= phase_nx;
            dir   <= dir_nx;
        end
    end

    // Next-phase logic
    always_comb begin
        phase_nx = phase;
        dir_nx   = dir;
        case (phase)
            PH_G1: if (pre_s || (tick && (call2 || ped_pending) && g1_time)) phase_nx = PH_Y1;
            PH_Y1: if (tick && (sec_inc >= YELT)) begin
                phase_nx = PH_AR;
                dir_nx   = 1'b0;
            end
            PH_AR: if (!pre_s && tick && (sec_inc >= ART))
                phase_nx = ped_pending ? PH_WK : (dir ? PH_G1 : PH_G2);
            PH_G2: if (pre_s || (tick && (call1 || ped_pending) && g2_time)) phase_nx = PH_Y2;
            PH_Y2: if (tick && (sec_inc >= YELT)) begin
                phase_nx = PH_AR;
                dir_nx   = 1'b1;
            end
            PH_WK: begin
                if (pre_s)                          phase_nx = PH_AR;
                else if (tick && (sec_inc >= WKT))  phase_nx = dir ? PH_G1 : PH_G2;
            end
            default: begin
                phase_nx = PH_AR;
                dir_nx   = 1'b1;
            end
        endcase
    end

    // Lamp decode; anything not a green/yellow phase shows both reds
    always_comb begin
        red1    = 1'b1;
        yellow1 = 1'b0;
        green1  = 1'b0;
        red2    = 1'b1;
        yellow2 = 1'b0;
        green2  = 1'b0;
        walk    = 1'b0;
        case (phase)
            PH_G1: begin green1  = 1'b1; red1 = 1'b0; end
            PH_Y1: begin yellow1 = 1'b1; red1 = 1'b0; end
            PH_G2: begin green2  = 1'b1; red2 = 1'b0; end
            PH_Y2: begin yellow2 = 1'b1; red2 = 1'b0; end
            PH_WK: walk = 1'b1;
            default: ;
        endcase
        dont_walk = ~walk;
    end

endmodule
